// File: rtl/hazard_stall_ctrl_if.sv
// Hazard/stall handshake bundle between the ID/EX pipeline stage and the stall controller.
// The master is the pipeline side; the slave is the stall controller.
interface hazard_stall_ctrl_if #(
  parameter int REG_W = 5
);
  logic [REG_W-1:0] IFID_Rs1;
  logic [REG_W-1:0] IFID_Rs2;
  logic             IFID_UseRs2;
  logic [REG_W-1:0] IDEX_Rd;
  logic             IDEX_MemRead;
  logic             IDEX_Mult;
  logic             IDEX_Valid;
  logic             ExtStall;
  logic             PC_Write;
  logic             IFID_Write;
  logic             IDEX_Write;
  logic             IDEX_Flush;
  logic             EXMEM_Flush;
  logic             MultStart;
  logic             MultBusy;

  modport master (
    output IFID_Rs1, IFID_Rs2, IFID_UseRs2, IDEX_Rd, IDEX_MemRead, IDEX_Mult,
           IDEX_Valid, ExtStall,
    input  PC_Write, IFID_Write, IDEX_Write, IDEX_Flush, EXMEM_Flush,
           MultStart, MultBusy
  );

  modport slave (
    input  IFID_Rs1, IFID_Rs2, IFID_UseRs2, IDEX_Rd, IDEX_MemRead, IDEX_Mult,
           IDEX_Valid, ExtStall,
    output PC_Write, IFID_Write, IDEX_Write, IDEX_Flush, EXMEM_Flush,
           MultStart, MultBusy
  );
endinterface

// File: rtl/hazard_stall_ctrl.sv
// Stall/bubble controller: holds the front end MULT_LAT-1 cycles per multiply, 1 cycle per load-use
// (load-use under HAZARD_LOAD_USE_STALL_EN); combinational outputs, ExtStall freezes everything.
module hazard_stall_ctrl #(
  parameter int MULT_LAT = 4,
  parameter int REG_W    = 5
) (
  input logic               clk,
  input logic               rst,
  hazard_stall_ctrl_if.slave bus
);
  localparam int CW = $clog2(MULT_LAT) + 1;
  localparam logic [CW-1:0] CNT_INIT = CW'((MULT_LAT > 1) ? (MULT_LAT - 2) : 0);

  typedef enum logic {RUN, MUL} state_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic          mult_det;
  logic          mul_hold;
  logic          load_use;

  assign mult_det = (state == RUN) && bus.IDEX_Valid && bus.IDEX_Mult;
  // A single-cycle multiplier never needs to hold the front end.
  assign mul_hold = ((state == MUL) && (cnt != '0)) || (mult_det && (MULT_LAT > 1));

`ifdef HAZARD_LOAD_USE_STALL_EN
  assign load_use = (state == RUN) && !mult_det && bus.IDEX_MemRead && bus.IDEX_Valid &&
                    (bus.IDEX_Rd != {REG_W{1'b0}}) &&
                    ((bus.IDEX_Rd == bus.IFID_Rs1) ||
                     (bus.IFID_UseRs2 && (bus.IDEX_Rd == bus.IFID_Rs2)));
`else
  assign load_use = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= RUN;
      cnt   <= '0;
    end else if (!bus.ExtStall) begin
      case (state)
        RUN: begin
          if (mult_det && (MULT_LAT > 1)) begin
            state <= MUL;
            cnt   <= CNT_INIT;
          end
        end
        MUL: begin
          if (cnt != '0) begin
            cnt <= cnt - CW'(1);
          end else begin
            state <= RUN;
          end
        end
        default: begin
          state <= RUN;
          cnt   <= '0;
        end
      endcase
    end
  end

  always_comb begin
    bus.PC_Write    = 1'b1;
    bus.IFID_Write  = 1'b1;
    bus.IDEX_Write  = 1'b1;
    bus.IDEX_Flush  = 1'b0;
    bus.EXMEM_Flush = 1'b0;
    bus.MultStart   = 1'b0;
    bus.MultBusy    = 1'b0;
    if (rst) begin
      bus.IDEX_Flush  = 1'b1;
      bus.EXMEM_Flush = 1'b1;
    end else if (bus.ExtStall) begin
      // Freeze: a pending start is simply re-evaluated once the stall drops.
      bus.PC_Write   = 1'b0;
      bus.IFID_Write = 1'b0;
      bus.IDEX_Write = 1'b0;
      bus.MultBusy   = (state == MUL) && (cnt != '0);
    end else if (mul_hold) begin
      bus.PC_Write    = 1'b0;
      bus.IFID_Write  = 1'b0;
      bus.IDEX_Write  = 1'b0;
      bus.EXMEM_Flush = 1'b1;
      bus.MultBusy    = 1'b1;
      bus.MultStart   = mult_det;
    end else if (mult_det) begin
      bus.MultStart = 1'b1;
    end else if (load_use) begin
      bus.PC_Write   = 1'b0;
      bus.IFID_Write = 1'b0;
      bus.IDEX_Flush = 1'b1;
    end
  end
endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Scoreboard bench for hazard_stall_ctrl with MULT_LAT=4; load-use expectations follow HAZARD_LOAD_USE_STALL_EN.
module tb_hazard_stall_ctrl;
  // Output vector order: {PC_Write, IFID_Write, IDEX_Write, IDEX_Flush, EXMEM_Flush, MultStart, MultBusy}
  localparam logic [6:0] NORM   = 7'b111_00_00;
  localparam logic [6:0] RSTV   = 7'b111_11_00;
  localparam logic [6:0] MSTART = 7'b000_01_11;
  localparam logic [6:0] MHOLD  = 7'b000_01_01;
  localparam logic [6:0] FRZ    = 7'b000_00_00;
  localparam logic [6:0] FRZB   = 7'b000_00_01;
`ifdef HAZARD_LOAD_USE_STALL_EN
  localparam logic [6:0] LU     = 7'b001_10_00;
`else
  localparam logic [6:0] LU     = NORM;
`endif

  typedef struct {
    string      tag;
    logic [6:0] exp;
  } sb_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   failures = 0;
  sb_t  sb[$];

  hazard_stall_ctrl_if #(.REG_W(5)) bus ();

  hazard_stall_ctrl #(.MULT_LAT(4), .REG_W(5)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [6:0] got, input logic [6:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%b exp=%b", tag, got, exp);
    end
  endtask

  task automatic step(input string tag, input logic r, input logic es, input logic v,
                      input logic m, input logic mr, input logic [4:0] rd,
                      input logic [4:0] rs1, input logic [4:0] rs2, input logic u2,
                      input logic [6:0] exp);
    sb_t e;
    @(posedge clk);
    #1;
    rst              = r;
    bus.ExtStall     = es;
    bus.IDEX_Valid   = v;
    bus.IDEX_Mult    = m;
    bus.IDEX_MemRead = mr;
    bus.IDEX_Rd      = rd;
    bus.IFID_Rs1     = rs1;
    bus.IFID_Rs2     = rs2;
    bus.IFID_UseRs2  = u2;
    sb.push_back('{tag, exp});
    @(negedge clk);
    if (sb.size() == 0) begin
      check({tag, "_sb_empty"}, 7'b0, 7'b1);
    end else begin
      e = sb.pop_front();
      check(e.tag, {bus.PC_Write, bus.IFID_Write, bus.IDEX_Write, bus.IDEX_Flush,
                    bus.EXMEM_Flush, bus.MultStart, bus.MultBusy}, e.exp);
    end
  endtask

  initial begin
    bus.ExtStall = 1'b0; bus.IDEX_Valid = 1'b0; bus.IDEX_Mult = 1'b0;
    bus.IDEX_MemRead = 1'b0; bus.IDEX_Rd = '0; bus.IFID_Rs1 = '0;
    bus.IFID_Rs2 = '0; bus.IFID_UseRs2 = 1'b0;

    // reset with a multiply sitting in EX, then back-to-back multiplies
    step("rst0",    1, 0, 1, 1, 0, 0, 0, 0, 0, RSTV);
    step("rst1",    1, 0, 1, 1, 0, 0, 0, 0, 0, RSTV);
    step("m1_t0",   0, 0, 1, 1, 0, 0, 0, 0, 0, MSTART);
    step("m1_t1",   0, 0, 1, 1, 0, 0, 0, 0, 0, MHOLD);
    step("m1_t2",   0, 0, 1, 1, 0, 0, 0, 0, 0, MHOLD);
    step("m1_t3",   0, 0, 1, 1, 0, 0, 0, 0, 0, NORM);
    step("m2_t0",   0, 0, 1, 1, 0, 0, 0, 0, 0, MSTART);
    step("m2_t1",   0, 0, 1, 1, 0, 0, 0, 0, 0, MHOLD);
    step("m2_t2",   0, 0, 1, 1, 0, 0, 0, 0, 0, MHOLD);
    step("m2_t3",   0, 0, 1, 1, 0, 0, 0, 0, 0, NORM);
    step("idle0",   0, 0, 0, 0, 0, 0, 0, 0, 0, NORM);

    // ExtStall for 3 cycles in the middle of a multiply
    step("es_t0",   0, 0, 1, 1, 0, 0, 0, 0, 0, MSTART);
    step("es_t1",   0, 1, 1, 1, 0, 0, 0, 0, 0, FRZB);
    step("es_t2",   0, 1, 1, 1, 0, 0, 0, 0, 0, FRZB);
    step("es_t3",   0, 1, 1, 1, 0, 0, 0, 0, 0, FRZB);
    step("es_t4",   0, 0, 1, 1, 0, 0, 0, 0, 0, MHOLD);
    step("es_t5",   0, 0, 1, 1, 0, 0, 0, 0, 0, MHOLD);
    step("es_t6",   0, 0, 1, 1, 0, 0, 0, 0, 0, NORM);
    step("idle1",   0, 0, 0, 0, 0, 0, 0, 0, 0, NORM);

    // start coinciding with ExtStall is deferred
    step("dfr_es",  0, 1, 1, 1, 0, 0, 0, 0, 0, FRZ);
    step("dfr_t0",  0, 0, 1, 1, 0, 0, 0, 0, 0, MSTART);
    step("dfr_t1",  0, 0, 1, 1, 0, 0, 0, 0, 0, MHOLD);
    step("dfr_t2",  0, 0, 1, 1, 0, 0, 0, 0, 0, MHOLD);
    step("dfr_t3",  0, 0, 1, 1, 0, 0, 0, 0, 0, NORM);

    // reset aborts a multiply
    step("ab_t0",   0, 0, 1, 1, 0, 0, 0, 0, 0, MSTART);
    step("ab_rst",  1, 0, 1, 1, 0, 0, 0, 0, 0, RSTV);
    step("ab_after",0, 0, 0, 0, 0, 0, 0, 0, 0, NORM);

    // load-use hazards
    step("lu_rs2",  0, 0, 1, 0, 1, 5, 3, 5, 1, LU);
    step("lu_next", 0, 0, 1, 0, 0, 9, 3, 5, 1, NORM);
    step("lu_rd0",  0, 0, 1, 0, 1, 0, 0, 0, 1, NORM);
    step("lu_rs1",  0, 0, 1, 0, 1, 7, 7, 2, 0, LU);
    step("lu_nou2", 0, 0, 1, 0, 1, 6, 1, 6, 0, NORM);
    step("lu_inv",  0, 0, 0, 0, 1, 5, 5, 5, 1, NORM);
    step("lu_es",   0, 1, 1, 0, 1, 5, 5, 5, 1, FRZ);
    step("lu_mul",  0, 0, 1, 1, 1, 5, 5, 5, 1, MSTART);
    step("lu_m_t1", 0, 0, 1, 1, 1, 5, 5, 5, 1, MHOLD);
    step("lu_m_t2", 0, 0, 1, 1, 1, 5, 5, 5, 1, MHOLD);
    step("lu_m_t3", 0, 0, 0, 0, 0, 0, 0, 0, 0, NORM);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
